// File: rtl/huffman_bit_packer.sv
// Packs variable-length Huffman codewords MSB-first into W-bit words, with flush of a zero-padded tail.
// Optional macro HUFF_PACK_STATS_EN enables the 32-bit accepted-bit counter on bits_total.
module huffman_bit_packer #(
    parameter int W  = 8,
    parameter int WL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  code_in,
    input  logic [WL-1:0] len_in,
    input  logic          en_in,
    output logic          in_ready,
    input  logic          flush,
    output logic [W-1:0]  d_out,
    output logic          en_out,
    input  logic          out_ready,
    output logic          flush_done,
    output logic [31:0]   bits_total
);
    localparam int FW = $clog2(2*W+1);

    typedef enum logic [1:0] {ST_ACTIVE, ST_FLUSH, ST_DONE} state_t;

    state_t          state_q, state_d;
    logic [2*W-1:0]  acc_q, acc_d, acc_s;
    logic [FW-1:0]   fill_q, fill_d, fill_s, shamt;
    logic [WL-1:0]   len_c;
    logic [W-1:0]    code_m;
    logic            in_fire, out_fire;

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign in_ready   = (state_q == ST_ACTIVE) && (fill_q <= FW'(W));
    assign en_out     = (fill_q >= FW'(W)) || ((state_q == ST_FLUSH) && (fill_q != '0));
    assign d_out      = acc_q[2*W-1 -: W];
    assign flush_done = (state_q == ST_DONE);

    always_comb begin
        in_fire  = en_in && in_ready;
        out_fire = en_out && out_ready;
        len_c    = (len_in > WL'(W)) ? WL'(W) : len_in;
        code_m   = code_in & ~({W{1'b1}} << len_c);

        acc_s  = acc_q;
        fill_s = fill_q;
        if (out_fire) begin
            acc_s  = acc_q << W;
            fill_s = (fill_q >= FW'(W)) ? fill_q - FW'(W) : '0;
        end

        // Codeword MSB lands just below the bits already held after any output shift.
        shamt  = FW'(2*W) - fill_s - FW'(len_c);
        acc_d  = acc_s;
        fill_d = fill_s;
        if (in_fire) begin
            acc_d  = acc_s | ({{W{1'b0}}, code_m} << shamt);
            fill_d = fill_s + FW'(len_c);
        end

        state_d = state_q;
        case (state_q)
            ST_ACTIVE: if (flush) state_d = ST_FLUSH;
            ST_FLUSH:  if (fill_d == '0) state_d = ST_DONE;
            ST_DONE:   state_d = ST_ACTIVE;
            default:   state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACTIVE;
            acc_q   <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            fill_q  <= fill_d;
        end
    end

`ifdef HUFF_PACK_STATS_EN
    logic [31:0] bits_total_q, bits_total_d;

    always_comb begin
        bits_total_d = bits_total_q;
        if (in_fire) bits_total_d = bits_total_q + 32'(len_c);
    end

    always_ff @(posedge clk) begin
        if (rst) bits_total_q <= '0;
        else     bits_total_q <= bits_total_d;
    end

    assign bits_total = bits_total_q;
`else
    assign bits_total = '0;
`endif

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Directed table-driven bench for huffman_bit_packer (W=8): per-cycle vectors plus a reset sequence.
module tb_huffman_bit_packer;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] code_in;
    logic [3:0] len_in;
    logic       en_in, in_ready, flush;
    logic [7:0] d_out;
    logic       en_out, out_ready, flush_done;
    logic [31:0] bits_total;

    int checks = 0;
    int failures = 0;
    int exp_bits = 0;

    huffman_bit_packer #(.W(8), .WL(4)) dut (
        .clk(clk), .rst(rst), .code_in(code_in), .len_in(len_in), .en_in(en_in),
        .in_ready(in_ready), .flush(flush), .d_out(d_out), .en_out(en_out),
        .out_ready(out_ready), .flush_done(flush_done), .bits_total(bits_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [7:0] code;
        logic [3:0] len;
        logic       fl;
        logic       ory;
        logic       x_en;
        logic [7:0] x_d;
        logic       x_ir;
        logic       x_fd;
    } vec_t;

    vec_t tv[26];

    function automatic vec_t mk(input logic en, input logic [7:0] code, input logic [3:0] len,
                                input logic fl, input logic ory, input logic x_en,
                                input logic [7:0] x_d, input logic x_ir, input logic x_fd);
        vec_t v;
        v.en = en; v.code = code; v.len = len; v.fl = fl; v.ory = ory;
        v.x_en = x_en; v.x_d = x_d; v.x_ir = x_ir; v.x_fd = x_fd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    function automatic int clamp_len(input logic [3:0] l);
        return (l > 4'd8) ? 8 : int'(l);
    endfunction

    initial begin
        //            en code  len  fl ory | en_out d_out in_rdy fdone
        tv[0]  = mk(1, 8'h02, 4'd2, 0, 1, 0, 8'h00, 1, 0);
        tv[1]  = mk(1, 8'h01, 4'd2, 0, 1, 0, 8'h80, 1, 0);
        tv[2]  = mk(1, 8'h03, 4'd2, 0, 1, 0, 8'h90, 1, 0);
        tv[3]  = mk(1, 8'h00, 4'd2, 0, 1, 0, 8'h9C, 1, 0);
        tv[4]  = mk(0, 8'h00, 4'd0, 0, 1, 1, 8'h9C, 1, 0);
        tv[5]  = mk(1, 8'h16, 4'd5, 0, 1, 0, 8'h00, 1, 0);
        tv[6]  = mk(1, 8'h1B, 4'd6, 0, 1, 0, 8'hB0, 1, 0);
        tv[7]  = mk(0, 8'h00, 4'd0, 0, 1, 1, 8'hB3, 0, 0);
        tv[8]  = mk(1, 8'h15, 4'd5, 0, 1, 0, 8'h60, 1, 0);
        tv[9]  = mk(0, 8'h00, 4'd0, 0, 1, 1, 8'h75, 1, 0);
        tv[10] = mk(1, 8'h07, 4'd3, 0, 1, 0, 8'h00, 1, 0);
        tv[11] = mk(0, 8'h00, 4'd0, 1, 1, 0, 8'hE0, 1, 0);
        tv[12] = mk(0, 8'h00, 4'd0, 0, 1, 1, 8'hE0, 0, 0);
        tv[13] = mk(0, 8'h00, 4'd0, 0, 1, 0, 8'h00, 0, 1);
        tv[14] = mk(0, 8'h00, 4'd0, 1, 1, 0, 8'h00, 1, 0);
        tv[15] = mk(0, 8'h00, 4'd0, 0, 1, 0, 8'h00, 0, 0);
        tv[16] = mk(0, 8'h00, 4'd0, 0, 1, 0, 8'h00, 0, 1);
        tv[17] = mk(1, 8'hAA, 4'd8, 0, 0, 0, 8'h00, 1, 0);
        tv[18] = mk(1, 8'h55, 4'd8, 0, 0, 1, 8'hAA, 1, 0);
        tv[19] = mk(1, 8'hC3, 4'd8, 0, 0, 1, 8'hAA, 0, 0);
        tv[20] = mk(1, 8'hC3, 4'd8, 0, 1, 1, 8'hAA, 0, 0);
        tv[21] = mk(1, 8'hC3, 4'd8, 0, 1, 1, 8'h55, 1, 0);
        tv[22] = mk(0, 8'h00, 4'd0, 0, 1, 1, 8'hC3, 1, 0);
        tv[23] = mk(1, 8'hFF, 4'd15, 0, 1, 0, 8'h00, 1, 0);
        tv[24] = mk(1, 8'h5A, 4'd0, 0, 1, 1, 8'hFF, 1, 0);
        tv[25] = mk(0, 8'h00, 4'd0, 0, 1, 0, 8'h00, 1, 0);

        rst = 1'b1; en_in = 1'b0; code_in = '0; len_in = '0; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_en_out", 0, 32'(en_out), 32'd0);
        chk("rst_d_out", 0, 32'(d_out), 32'd0);
        chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
        chk("rst_flush_done", 0, 32'(flush_done), 32'd0);
        chk("rst_bits_total", 0, bits_total, 32'd0);

        for (int i = 0; i < 26; i++) begin
            chk("en_out", i, 32'(en_out), 32'(tv[i].x_en));
            chk("d_out", i, 32'(d_out), 32'(tv[i].x_d));
            chk("in_ready", i, 32'(in_ready), 32'(tv[i].x_ir));
            chk("flush_done", i, 32'(flush_done), 32'(tv[i].x_fd));
            chk("bits_total", i, bits_total, 32'(exp_bits));
`ifdef HUFF_PACK_STATS_EN
            if (tv[i].en && tv[i].x_ir) exp_bits += clamp_len(tv[i].len);
`endif
            en_in = tv[i].en; code_in = tv[i].code; len_in = tv[i].len;
            flush = tv[i].fl; out_ready = tv[i].ory;
            @(negedge clk);
        end

        // Load 5 bits, then reset: buffered bits must vanish and the next 8 bits form a clean word.
        en_in = 1'b1; code_in = 8'h1F; len_in = 4'd5; flush = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("pre_rst_d_out", 100, 32'(d_out), 32'hF8);
        en_in = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_bits = 0;
        chk("post_rst_en_out", 101, 32'(en_out), 32'd0);
        chk("post_rst_d_out", 101, 32'(d_out), 32'd0);
        chk("post_rst_in_ready", 101, 32'(in_ready), 32'd1);
        chk("post_rst_bits_total", 101, bits_total, 32'd0);
        en_in = 1'b1; code_in = 8'h0A; len_in = 4'd4;
        @(negedge clk);
        code_in = 8'h05; len_in = 4'd4;
        @(negedge clk);
        en_in = 1'b0;
`ifdef HUFF_PACK_STATS_EN
        exp_bits = 8;
`endif
        chk("clean_en_out", 102, 32'(en_out), 32'd1);
        chk("clean_d_out", 102, 32'(d_out), 32'hA5);
        chk("clean_bits_total", 102, bits_total, 32'(exp_bits));
        @(negedge clk);
        chk("drained_en_out", 103, 32'(en_out), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
